// File: rtl/rob_nway_squash.sv
// N-wide reorder buffer: C completion ports, in-order N-wide retire, mispredict squash.
// Define ROB_EXC_EN to add cmp_exc/exc_pulse and the precise exception flush.
module rob_nway_squash #(
  parameter int DEPTH  = 32,
  parameter int N      = 3,
  parameter int C      = 3,
  parameter int PREG_W = 6,
  parameter int ARCH_W = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(N+1)-1:0]     num_accept,
  input  logic [N*PREG_W-1:0]        disp_t,
  input  logic [N*PREG_W-1:0]        disp_t_old,
  input  logic [N*ARCH_W-1:0]        disp_dest,
  output logic [N*$clog2(DEPTH)-1:0] disp_idx,
  input  logic [C-1:0]               cmp_valid,
  input  logic [C*$clog2(DEPTH)-1:0] cmp_idx,
  input  logic [C-1:0]               cmp_mispred,
`ifdef ROB_EXC_EN
  input  logic [C-1:0]               cmp_exc,
  output logic                       exc_pulse,
`endif
  output logic [N-1:0]               ret_valid,
  output logic [N*PREG_W-1:0]        ret_t,
  output logic [N*PREG_W-1:0]        ret_t_old,
  output logic [N*ARCH_W-1:0]        ret_dest,
  output logic                       squash,
  output logic [$clog2(DEPTH+1)-1:0] open_entries
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(N+1);

  logic [IW-1:0]     head_q, head_d;
  logic [IW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              squash_q, squash_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  cmpl_q, cmpl_d;
  logic [DEPTH-1:0]  mis_q, mis_d;
  logic [DEPTH-1:0]  exc_q, exc_d;
  logic [PREG_W-1:0] t_q [DEPTH];
  logic [PREG_W-1:0] t_d [DEPTH];
  logic [PREG_W-1:0] told_q [DEPTH];
  logic [PREG_W-1:0] told_d [DEPTH];
  logic [ARCH_W-1:0] dest_q [DEPTH];
  logic [ARCH_W-1:0] dest_d [DEPTH];

  logic [IW-1:0] rslot [N];
  logic [IW-1:0] dslot [N];
  logic [IW-1:0] cslot [C];
  logic [AW-1:0] ret_cnt;
  logic [AW-1:0] acc;
  logic [CW-1:0] max_acc;
  logic          mis_hit;
  logic          exc_hit;
  logic          flush;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign rslot[g] = head_q + IW'(g);
    assign dslot[g] = tail_q + IW'(g);
    assign disp_idx[g*IW +: IW] = dslot[g];
  end

  for (genvar g = 0; g < C; g++) begin : g_cmp
    assign cslot[g] = cmp_idx[g*IW +: IW];
  end

  assign open_entries = CW'(DEPTH) - count_q;
  assign max_acc = (open_entries < CW'(N)) ? open_entries : CW'(N);
  assign acc = (CW'(num_accept) > max_acc) ? max_acc[AW-1:0] : num_accept;
  assign flush = mis_hit | exc_hit;
  assign squash = squash_q;
`ifdef ROB_EXC_EN
  assign exc_pulse = exc_hit;
`endif

  // Lane i retires only if every older lane retired and none was a mispredict.
  always_comb begin
    ret_valid = '0;
    ret_cnt   = '0;
    mis_hit   = 1'b0;
    exc_hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ret_cnt == AW'(i) && !mis_hit && !exc_hit &&
          valid_q[rslot[i]] && cmpl_q[rslot[i]]) begin
        if (exc_q[rslot[i]]) begin
          exc_hit = 1'b1;
        end else begin
          ret_valid[i] = 1'b1;
          ret_cnt      = ret_cnt + AW'(1);
          mis_hit      = mis_q[rslot[i]];
        end
      end
    end
  end

  always_comb begin
    ret_t     = '0;
    ret_t_old = '0;
    ret_dest  = '0;
    for (int i = 0; i < N; i++) begin
      if (ret_valid[i]) begin
        ret_t[i*PREG_W +: PREG_W]     = t_q[rslot[i]];
        ret_t_old[i*PREG_W +: PREG_W] = told_q[rslot[i]];
        ret_dest[i*ARCH_W +: ARCH_W]  = dest_q[rslot[i]];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    cmpl_d  = cmpl_q;
    mis_d   = mis_q;
    exc_d   = exc_q;
    t_d     = t_q;
    told_d  = told_q;
    dest_d  = dest_q;
    for (int c = 0; c < C; c++) begin
      if (cmp_valid[c] && valid_q[cslot[c]]) begin
        cmpl_d[cslot[c]] = 1'b1;
        mis_d[cslot[c]]  = mis_d[cslot[c]] | cmp_mispred[c];
`ifdef ROB_EXC_EN
        exc_d[cslot[c]]  = exc_d[cslot[c]] | cmp_exc[c];
`endif
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ret_valid[i]) begin
        valid_d[rslot[i]] = 1'b0;
        cmpl_d[rslot[i]]  = 1'b0;
        mis_d[rslot[i]]   = 1'b0;
        exc_d[rslot[i]]   = 1'b0;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (AW'(j) < acc) begin
        valid_d[dslot[j]] = 1'b1;
        cmpl_d[dslot[j]]  = 1'b0;
        mis_d[dslot[j]]   = 1'b0;
        exc_d[dslot[j]]   = 1'b0;
        t_d[dslot[j]]     = disp_t[j*PREG_W +: PREG_W];
        told_d[dslot[j]]  = disp_t_old[j*PREG_W +: PREG_W];
        dest_d[dslot[j]]  = disp_dest[j*ARCH_W +: ARCH_W];
      end
    end
    if (flush) begin
      valid_d = '0;
      cmpl_d  = '0;
      mis_d   = '0;
      exc_d   = '0;
    end
    head_d   = head_q + IW'(ret_cnt);
    tail_d   = flush ? head_d : tail_q + IW'(acc);
    count_d  = flush ? '0 : count_q + CW'(acc) - CW'(ret_cnt);
    squash_d = mis_hit;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      squash_q <= 1'b0;
      valid_q  <= '0;
      cmpl_q   <= '0;
      mis_q    <= '0;
      exc_q    <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      squash_q <= squash_d;
      valid_q  <= valid_d;
      cmpl_q   <= cmpl_d;
      mis_q    <= mis_d;
      exc_q    <= exc_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clock) begin
    t_q    <= t_d;
    told_q <= told_d;
    dest_q <= dest_d;
  end

  a_disp_fit: assert property (@(posedge clock) disable iff (!reset)
    CW'(num_accept) <= max_acc);

endmodule

// File: tb/tb_rob_nway_squash.sv
// Bench for rob_nway_squash: queue-based ROB model checked every cycle,
// directed corner cases with literal expectations, then random traffic.
module tb_rob_nway_squash;
  localparam int DEPTH  = 32;
  localparam int N      = 3;
  localparam int C      = 3;
  localparam int PREG_W = 6;
  localparam int ARCH_W = 5;
  localparam int IW     = 5;
  localparam int CW     = 6;
  localparam int AW     = 2;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [AW-1:0]        num_accept = '0;
  logic [N*PREG_W-1:0]  disp_t = '0;
  logic [N*PREG_W-1:0]  disp_t_old = '0;
  logic [N*ARCH_W-1:0]  disp_dest = '0;
  logic [N*IW-1:0]      disp_idx;
  logic [C-1:0]         cmp_valid = '0;
  logic [C*IW-1:0]      cmp_idx = '0;
  logic [C-1:0]         cmp_mispred = '0;
  logic [N-1:0]         ret_valid;
  logic [N*PREG_W-1:0]  ret_t;
  logic [N*PREG_W-1:0]  ret_t_old;
  logic [N*ARCH_W-1:0]  ret_dest;
  logic                 squash;
  logic [CW-1:0]        open_entries;

  always #5 clock = ~clock;

  rob_nway_squash #(
    .DEPTH(DEPTH), .N(N), .C(C), .PREG_W(PREG_W), .ARCH_W(ARCH_W)
  ) dut (
    .clock(clock), .reset(reset),
    .num_accept(num_accept),
    .disp_t(disp_t), .disp_t_old(disp_t_old), .disp_dest(disp_dest),
    .disp_idx(disp_idx),
    .cmp_valid(cmp_valid), .cmp_idx(cmp_idx), .cmp_mispred(cmp_mispred),
    .ret_valid(ret_valid),
    .ret_t(ret_t), .ret_t_old(ret_t_old), .ret_dest(ret_dest),
    .squash(squash), .open_entries(open_entries)
  );

  typedef struct {
    int t;
    int told;
    int dest;
    bit done;
    bit mis;
  } ent_t;

  ent_t mq[$];
  int   m_head;
  bit   m_squash;
  int   seq;
  bit   rnd_data;
  int   n_cmp;
  int   n_bad;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic logic [C*IW-1:0] pk(input int a, input int b, input int c);
    logic [C*IW-1:0] v;
    v = '0;
    v[0 +: IW]    = IW'(a);
    v[IW +: IW]   = IW'(b);
    v[2*IW +: IW] = IW'(c);
    return v;
  endfunction

  // Oldest-first walk: stop at the first incomplete entry, or just after a mispredict.
  function automatic int exp_k(output bit sq);
    int k;
    k  = 0;
    sq = 1'b0;
    while (k < N && k < mq.size() && mq[k].done) begin
      k++;
      if (mq[k-1].mis) begin
        sq = 1'b1;
        break;
      end
    end
    return k;
  endfunction

  task automatic cycle(input int na, input logic [C-1:0] cv,
                       input logic [C*IW-1:0] ci, input logic [C-1:0] cm);
    bit   sq;
    int   k;
    ent_t ne[$];
    k = exp_k(sq);
    chk("open_entries", int'(open_entries), DEPTH - mq.size());
    chk("ret_valid", int'(ret_valid), (1 << k) - 1);
    chk("squash", int'(squash), int'(m_squash));
    for (int j = 0; j < N; j++)
      chk("disp_idx", int'(disp_idx[j*IW +: IW]), (m_head + mq.size() + j) % DEPTH);
    for (int i = 0; i < k; i++) begin
      chk("ret_t", int'(ret_t[i*PREG_W +: PREG_W]), mq[i].t);
      chk("ret_t_old", int'(ret_t_old[i*PREG_W +: PREG_W]), mq[i].told);
      chk("ret_dest", int'(ret_dest[i*ARCH_W +: ARCH_W]), mq[i].dest);
    end
    num_accept = AW'(na);
    for (int j = 0; j < N; j++) begin
      ent_t e;
      if (rnd_data || j >= na) begin
        e.t    = int'($urandom_range(0, 63));
        e.told = int'($urandom_range(0, 63));
        e.dest = int'($urandom_range(0, 31));
      end else begin
        e.t    = (seq * 5 + 1) % 64;
        e.told = (seq + 40) % 64;
        e.dest = (seq + 3) % 32;
      end
      e.done = 1'b0;
      e.mis  = 1'b0;
      disp_t[j*PREG_W +: PREG_W]     = PREG_W'(e.t);
      disp_t_old[j*PREG_W +: PREG_W] = PREG_W'(e.told);
      disp_dest[j*ARCH_W +: ARCH_W]  = ARCH_W'(e.dest);
      if (j < na) begin
        ne.push_back(e);
        seq++;
      end
    end
    cmp_valid   = cv;
    cmp_idx     = ci;
    cmp_mispred = cm;
    @(posedge clock);
    for (int c = 0; c < C; c++) begin
      if (cv[c]) begin
        int   off;
        ent_t e;
        off = (int'(ci[c*IW +: IW]) - m_head + DEPTH) % DEPTH;
        if (off < mq.size()) begin
          e = mq[off];
          e.done = 1'b1;
          if (cm[c]) e.mis = 1'b1;
          mq[off] = e;
        end
      end
    end
    repeat (k) void'(mq.pop_front());
    m_head = (m_head + k) % DEPTH;
    if (sq) mq.delete();
    else foreach (ne[i]) mq.push_back(ne[i]);
    m_squash = sq;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    num_accept  = '0;
    cmp_valid   = '0;
    cmp_idx     = '0;
    cmp_mispred = '0;
    #2;
    chk("rst_open", int'(open_entries), DEPTH);
    chk("rst_ret_valid", int'(ret_valid), 0);
    chk("rst_squash", int'(squash), 0);
    mq.delete();
    m_head   = 0;
    m_squash = 1'b0;
    seq      = 0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rnd_data = 1'b0;

    // Three full-width dispatches, then out-of-order completion.
    do_reset();
    chk("idx_a", int'(disp_idx), int'(pk(0, 1, 2)));
    cycle(3, '0, '0, '0);
    chk("idx_b", int'(disp_idx), int'(pk(3, 4, 5)));
    chk("open_29", int'(open_entries), 29);
    cycle(3, '0, '0, '0);
    chk("idx_c", int'(disp_idx), int'(pk(6, 7, 8)));
    chk("open_26", int'(open_entries), 26);
    cycle(3, '0, '0, '0);
    chk("open_23", int'(open_entries), 23);
    chk("empty_ret", int'(ret_valid), 0);
    cycle(0, 3'b011, pk(1, 2, 0), '0);
    chk("no_retire", int'(ret_valid), 0);
    cycle(0, 3'b001, pk(0, 0, 0), '0);
    chk("ret3_valid", int'(ret_valid), 7);
    chk("ret3_t", int'(ret_t), 45441);
    chk("ret3_t_old", int'(ret_t_old), 174696);
    chk("ret3_dest", int'(ret_dest), 5251);
    cycle(0, '0, '0, '0);
    chk("open_back_26", int'(open_entries), 26);

    // Mispredict at slot 5 with head at 4.
    do_reset();
    cycle(3, '0, '0, '0);
    cycle(1, 3'b111, pk(0, 1, 2), '0);
    cycle(3, 3'b001, pk(3, 0, 0), '0);
    cycle(3, '0, '0, '0);
    cycle(0, 3'b011, pk(5, 4, 0), 3'b001);
    chk("mis_ret_valid", int'(ret_valid), 3);
    chk("mis_ret_t", int'(ret_t[2*PREG_W-1:0]), 1685);
    cycle(2, 3'b100, pk(0, 0, 6), '0);
    chk("mis_squash", int'(squash), 1);
    chk("mis_open", int'(open_entries), DEPTH);
    chk("mis_tail", int'(disp_idx[IW-1:0]), 6);
    cycle(0, '0, '0, '0);
    chk("mis_squash_end", int'(squash), 0);

    // Fill to full, then retire three.
    do_reset();
    repeat (10) cycle(3, '0, '0, '0);
    cycle(2, '0, '0, '0);
    chk("full_open", int'(open_entries), 0);
    cycle(0, 3'b111, pk(0, 1, 2), '0);
    chk("full_ret", int'(ret_valid), 7);
    chk("full_tail", int'(disp_idx[IW-1:0]), 0);
    cycle(0, '0, '0, '0);
    chk("full_open3", int'(open_entries), 3);

    // Drive head to 30 and dispatch across the wrap.
    do_reset();
    begin
      int tot;
      int g;
      tot = 0;
      g   = 0;
      while ((m_head != 30 || mq.size() != 0) && g < 200) begin
        int              na;
        int              n;
        logic [C-1:0]    cv;
        logic [C*IW-1:0] ci;
        na = (30 - tot < N) ? 30 - tot : N;
        n  = 0;
        cv = '0;
        ci = '0;
        for (int k = 0; k < mq.size() && n < C; k++) begin
          if (!mq[k].done) begin
            cv[n] = 1'b1;
            ci[n*IW +: IW] = IW'((m_head + k) % DEPTH);
            n++;
          end
        end
        cycle(na, cv, ci, '0);
        tot += na;
        g++;
      end
    end
    chk("wrap_idx", int'(disp_idx), int'(pk(30, 31, 0)));
    cycle(3, '0, '0, '0);
    cycle(0, 3'b111, pk(30, 31, 0), '0);
    chk("wrap_ret", int'(ret_valid), 7);
    cycle(0, '0, '0, '0);
    chk("wrap_tail", int'(disp_idx[IW-1:0]), 1);
    chk("wrap_open", int'(open_entries), DEPTH);

    // Random traffic with an asynchronous reset in the middle.
    do_reset();
    rnd_data = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      int              opn;
      int              mx;
      logic [C-1:0]    cv;
      logic [C*IW-1:0] ci;
      logic [C-1:0]    cm;
      if (it == 1500) do_reset();
      opn = DEPTH - mq.size();
      mx  = (opn < N) ? opn : N;
      cv  = '0;
      ci  = '0;
      cm  = '0;
      for (int c = 0; c < C; c++) begin
        cv[c] = ($urandom_range(0, 9) < 7);
        if (mq.size() > 0 && $urandom_range(0, 9) < 9)
          ci[c*IW +: IW] = IW'((m_head + int'($urandom_range(0, mq.size() - 1))) % DEPTH);
        else
          ci[c*IW +: IW] = IW'($urandom_range(0, DEPTH - 1));
        cm[c] = ($urandom_range(0, 99) < 3);
      end
      cycle(int'($urandom_range(0, mx)), cv, ci, cm);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
